// File: rtl/uart_tx_arbiter_if.sv
// Bus between N_REQ byte requesters and the UART transmitter arbiter.
// Requester side: i_req, i_data, i_last (flattened per requester).
// Transmitter side: i_txdone in, o_txstart/o_din out.
// Status: o_ack (byte consumed), o_grant (owner), o_busy.
interface uart_tx_arbiter_if #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned N_REQ   = 4
);
  logic [N_REQ-1:0]         i_req;
  logic [N_REQ*NB_DATA-1:0] i_data;
  logic [N_REQ-1:0]         i_last;
  logic                     i_txdone;
  logic                     o_txstart;
  logic [NB_DATA-1:0]       o_din;
  logic [N_REQ-1:0]         o_ack;
  logic [N_REQ-1:0]         o_grant;
  logic                     o_busy;

  // Requesters and transmitter model drive the inputs, observe the outputs.
  modport master (
    output i_req, i_data, i_last, i_txdone,
    input  o_txstart, o_din, o_ack, o_grant, o_busy
  );

  // Arbiter side.
  modport slave (
    input  i_req, i_data, i_last, i_txdone,
    output o_txstart, o_din, o_ack, o_grant, o_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ requesters.
// A granted requester owns the transmitter until it sends a byte flagged
// last, or until it stalls for HOLD_TIMEOUT cycles between bytes.
// Ports:
//   i_clk    - system clock, rising edge
//   i_reset  - asynchronous active-high reset
//   bus      - uart_tx_arbiter_if.slave: requests/bytes in, start/byte/ack/
//              grant/busy out (all outputs registered)
module uart_tx_arbiter #(
  parameter int unsigned NB_DATA      = 8,
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned HOLD_TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_owner_q, last_owner_d;
  logic                 last_flag_q, last_flag_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NB_DATA-1:0]   din_q, din_d;
  logic                 txstart_q, txstart_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic                 busy_q, busy_d;

  logic [OW-1:0]        cand;
  logic [OW-1:0]        pick_idx;
  logic                 pick_found;
  logic [OW-1:0]        cap_idx;
  logic [NB_DATA-1:0]   cap_data;
  logic                 cap_last;

  // Round-robin search starting just above the previous owner.
  always_comb begin
    cand       = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = OW'((32'(last_owner_q) + 32'd1 + k) % N_REQ);
      if (!pick_found && bus.i_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Byte/last of the requester being captured: new winner in IDLE, else owner.
  always_comb begin
    cap_idx  = (state_q == IDLE) ? pick_idx : owner_q;
    cap_data = '0;
    cap_last = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (cap_idx == OW'(k)) begin
        cap_data = bus.i_data[k*NB_DATA +: NB_DATA];
        cap_last = bus.i_last[k];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    last_flag_d  = last_flag_q;
    cnt_d        = cnt_q;
    din_d        = din_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d     = pick_idx;
          din_d       = cap_data;
          last_flag_d = cap_last;
          state_d     = SEND;
        end
      end
      SEND: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.i_txdone) begin
          if (last_flag_q) begin
            last_owner_d = owner_q;
            state_d      = IDLE;
          end else if (bus.i_req[owner_q]) begin
            din_d       = cap_data;
            last_flag_d = cap_last;
            state_d     = SEND;
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.i_req[owner_q]) begin
          din_d       = cap_data;
          last_flag_d = cap_last;
          state_d     = SEND;
        end else if (cnt_q == CNT_MAX) begin
          last_owner_d = owner_q;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs derived from the next state so they line up with it.
    txstart_d = (state_d == SEND);
    busy_d    = (state_d != IDLE);
    grant_d   = busy_d ? (N_REQ'(1) << owner_d) : '0;
    ack_d     = txstart_d ? (N_REQ'(1) << owner_d) : '0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_IDX;
      last_flag_q  <= 1'b0;
      cnt_q        <= '0;
      din_q        <= '0;
      txstart_q    <= 1'b0;
      ack_q        <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      last_flag_q  <= last_flag_d;
      cnt_q        <= cnt_d;
      din_q        <= din_d;
      txstart_q    <= txstart_d;
      ack_q        <= ack_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.o_txstart = txstart_q;
  assign bus.o_din     = din_q;
  assign bus.o_ack     = ack_q;
  assign bus.o_grant   = grant_q;
  assign bus.o_busy    = busy_q;

endmodule
